// File: rtl/counter_reader.sv
// Snapshots two event counters on request and streams them out LSB-first as bytes over valid/ready.
// Define COUNTER_READER_CHECKSUM_EN to append an XOR checksum byte to each frame.
module counter_reader #(
    parameter int CNT_W = 64
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Req,
    input  logic [CNT_W-1:0] Cnt0,
    input  logic [CNT_W-1:0] Cnt1,
    output logic             Busy,
    output logic [7:0]       Dout,
    output logic             Dvalid,
    input  logic             Dready,
    output logic             Dlast
);

    localparam int N     = 2 * CNT_W / 8;
    localparam int IDX_W = $clog2(N + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

`ifdef COUNTER_READER_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE, SEND, CSUM} state_t;
    logic [7:0] csum;
`else
    typedef enum logic [0:0] {IDLE, SEND} state_t;
`endif

    state_t             state;
    logic [CNT_W-1:0]   snap0;
    logic [CNT_W-1:0]   snap1;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   next_idx;
    logic [2*CNT_W-1:0] payload;
    logic [7:0]         next_byte;

    // Byte selection always looks one ahead so Dout is registered when presented.
    always_comb begin
        payload   = {snap1, snap0};
        next_idx  = idx + IDX_W'(1);
        next_byte = 8'(payload >> {next_idx, 3'b000});
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state  <= IDLE;
            snap0  <= '0;
            snap1  <= '0;
            idx    <= '0;
            Busy   <= 1'b0;
            Dout   <= 8'h00;
            Dvalid <= 1'b0;
            Dlast  <= 1'b0;
`ifdef COUNTER_READER_CHECKSUM_EN
            csum   <= 8'h00;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (Req) begin
                        state  <= SEND;
                        snap0  <= Cnt0;
                        snap1  <= Cnt1;
                        idx    <= '0;
                        Busy   <= 1'b1;
                        Dout   <= Cnt0[7:0];
                        Dvalid <= 1'b1;
                        Dlast  <= 1'b0;
`ifdef COUNTER_READER_CHECKSUM_EN
                        csum   <= 8'h00;
`endif
                    end
                end
                SEND: begin
                    if (Dvalid && Dready) begin
`ifdef COUNTER_READER_CHECKSUM_EN
                        csum <= csum ^ Dout;
`endif
                        if (idx == LAST_IDX) begin
`ifdef COUNTER_READER_CHECKSUM_EN
                            // Fold in the byte being accepted now; csum lags by one.
                            state <= CSUM;
                            idx   <= next_idx;
                            Dout  <= csum ^ Dout;
                            Dlast <= 1'b1;
`else
                            state  <= IDLE;
                            Busy   <= 1'b0;
                            Dvalid <= 1'b0;
                            Dlast  <= 1'b0;
                            Dout   <= 8'h00;
`endif
                        end else begin
                            idx  <= next_idx;
                            Dout <= next_byte;
`ifdef COUNTER_READER_CHECKSUM_EN
                            Dlast <= 1'b0;
`else
                            Dlast <= (next_idx == LAST_IDX);
`endif
                        end
                    end
                end
`ifdef COUNTER_READER_CHECKSUM_EN
                CSUM: begin
                    if (Dvalid && Dready) begin
                        state  <= IDLE;
                        Busy   <= 1'b0;
                        Dvalid <= 1'b0;
                        Dlast  <= 1'b0;
                        Dout   <= 8'h00;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_counter_reader.sv
// Directed bench for counter_reader: table of frames plus hand sequences for reset, back-to-back requests.
module tb_counter_reader;

    localparam int CNT_W = 64;
    localparam int N     = 2 * CNT_W / 8;
`ifdef COUNTER_READER_CHECKSUM_EN
    localparam int FLEN  = N + 1;
`else
    localparam int FLEN  = N;
`endif

    logic             Clk = 1'b0;
    logic             Reset_n;
    logic             Req;
    logic [CNT_W-1:0] Cnt0;
    logic [CNT_W-1:0] Cnt1;
    logic             Busy;
    logic [7:0]       Dout;
    logic             Dvalid;
    logic             Dready;
    logic             Dlast;

    counter_reader #(.CNT_W(CNT_W)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Req(Req), .Cnt0(Cnt0), .Cnt1(Cnt1),
        .Busy(Busy), .Dout(Dout), .Dvalid(Dvalid), .Dready(Dready), .Dlast(Dlast)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [63:0] c0;
        logic [63:0] c1;
        logic [7:0]  rdy;
        bit          inc;
        bit          req_busy;
        string       name;
    } vec_t;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] basic_bytes[$];
    vec_t       vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [63:0] c0, input logic [63:0] c1, input logic [7:0] rdy,
                                input bit inc, input bit req_busy, input string name);
        vec_t v;
        v.c0 = c0; v.c1 = c1; v.rdy = rdy; v.inc = inc; v.req_busy = req_busy; v.name = name;
        return v;
    endfunction

    task automatic build_expected(input logic [63:0] c0, input logic [63:0] c1);
        logic [7:0] x;
        x = 8'h00;
        exp_q = {};
        for (int i = 0; i < 8; i++) begin exp_q.push_back(c0[i*8 +: 8]); x ^= c0[i*8 +: 8]; end
        for (int i = 0; i < 8; i++) begin exp_q.push_back(c1[i*8 +: 8]); x ^= c1[i*8 +: 8]; end
`ifdef COUNTER_READER_CHECKSUM_EN
        exp_q.push_back(x);
`endif
    endtask

    task automatic run_frame(input vec_t v);
        int cyc;
        int sent;
        got_q = {};
        build_expected(v.c0, v.c1);
        @(negedge Clk);
        Cnt0 = v.c0; Cnt1 = v.c1; Req = 1'b1; Dready = 1'b0;
        @(negedge Clk);
        Req = 1'b0;
        cyc = 0; sent = 0;
        while (exp_q.size() > 0 && cyc < 200) begin
            check({v.name, ".busy"},   64'(Busy),   64'd1);
            check({v.name, ".dvalid"}, 64'(Dvalid), 64'd1);
            check({v.name, ".dout"},   64'(Dout),   64'(exp_q[0]));
            check({v.name, ".dlast"},  64'(Dlast),  64'(exp_q.size() == 1));
            Dready = v.rdy[cyc % 8];
            if (v.inc) Cnt0 = Cnt0 + 64'd1;
            Req = v.req_busy && (sent == 4 || exp_q.size() == 1);
            if (Dready) begin
                got_q.push_back(Dout);
                void'(exp_q.pop_front());
                sent++;
            end
            cyc++;
            @(negedge Clk);
        end
        check({v.name, ".timeout_left"}, 64'(exp_q.size()), 64'd0);
        Req = 1'b0; Dready = 1'b0;
        check({v.name, ".end_busy"},   64'(Busy),   64'd0);
        check({v.name, ".end_dvalid"}, 64'(Dvalid), 64'd0);
        @(negedge Clk);
        check({v.name, ".idle_busy"},  64'(Busy),   64'd0);
    endtask

    initial begin
        Reset_n = 1'b0; Req = 1'b0; Dready = 1'b0; Cnt0 = '0; Cnt1 = '0;

        vecs[0] = mk(64'h0123456789ABCDEF, 64'h3, 8'hFF, 1'b0, 1'b0, "basic");
        vecs[1] = mk(64'h0123456789ABCDEF, 64'h3, 8'h99, 1'b0, 1'b0, "backpressure");
        vecs[2] = mk(64'h00000000000000FE, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 1'b1, 1'b0, "snapshot");
        vecs[3] = mk(64'hA5A5A5A5A5A5A5A5, 64'h5A5A5A5A5A5A5A5A, 8'h6D, 1'b0, 1'b1, "req_busy");
        vecs[4] = mk(64'h0, 64'h0, 8'hFF, 1'b0, 1'b0, "zeros");
        basic_bytes = '{8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01,
                        8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
`ifdef COUNTER_READER_CHECKSUM_EN
        basic_bytes.push_back(8'h03);
`endif

        #2;
        check("reset.busy",   64'(Busy),   64'd0);
        check("reset.dvalid", 64'(Dvalid), 64'd0);
        check("reset.dlast",  64'(Dlast),  64'd0);
        check("reset.dout",   64'(Dout),   64'd0);
        @(negedge Clk);
        Reset_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            run_frame(vecs[i]);
            if (i < 2) begin
                check({vecs[i].name, ".len"}, 64'(got_q.size()), 64'(FLEN));
                for (int b = 0; b < FLEN && b < got_q.size(); b++)
                    check({vecs[i].name, ".literal"}, 64'(got_q[b]), 64'(basic_bytes[b]));
            end
        end

        // Req held high: exactly one idle cycle between frames.
        @(negedge Clk);
        Cnt0 = 64'h1122334455667788; Cnt1 = 64'h0; Req = 1'b1; Dready = 1'b1;
        @(negedge Clk);
        check("hold.first_dout", 64'(Dout), 64'h88);
        repeat (FLEN - 1) @(negedge Clk);
        check("hold.dlast", 64'(Dlast), 64'd1);
        @(negedge Clk);
        check("hold.gap_busy",   64'(Busy),   64'd0);
        check("hold.gap_dvalid", 64'(Dvalid), 64'd0);
        @(negedge Clk);
        check("hold.restart_busy", 64'(Busy), 64'd1);
        check("hold.restart_dout", 64'(Dout), 64'h88);
        Req = 1'b0;
        for (int c = 0; c < 40 && Busy; c++) @(negedge Clk);
        check("hold.drain_busy", 64'(Busy), 64'd0);

        // Asynchronous reset in the middle of a frame, at idx 5.
        @(negedge Clk);
        Cnt0 = 64'h0123456789ABCDEF; Cnt1 = 64'h3; Req = 1'b1; Dready = 1'b1;
        @(negedge Clk);
        Req = 1'b0;
        repeat (5) @(negedge Clk);
        check("midreset.pre_dout", 64'(Dout), 64'h45);
        #2 Reset_n = 1'b0;
        #1;
        check("midreset.busy",   64'(Busy),   64'd0);
        check("midreset.dvalid", 64'(Dvalid), 64'd0);
        check("midreset.dlast",  64'(Dlast),  64'd0);
        check("midreset.dout",   64'(Dout),   64'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        repeat (4) begin
            @(negedge Clk);
            check("postreset.busy",   64'(Busy),   64'd0);
            check("postreset.dvalid", 64'(Dvalid), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
